// File: rtl/led_rr_arbiter_pkg.sv
// Shared LED arbitration package.
//   LED_W      default LED bank width
//   state_e    arbiter FSM states
//   next_index round-robin search helper, reusable by other arbiters (<= MAX_REQ requesters)
package led_pkg;

  localparam int unsigned LED_W   = 5;
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Search starts at last+1 and wraps, so the previous winner is considered last.
  function automatic rr_pick_t next_index(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         last,
                                          input int unsigned        n);
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = 32'(last) + k;
      if (cand >= n) cand = cand - n;
      if (k <= n && !pick.found && req[3'(cand)]) begin
        pick.found = 1'b1;
        pick.idx   = 3'(cand);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_rr_arbiter_if.sv
// Requester/LED bus of the round-robin LED arbiter.
//   req  per-requester level request
//   pat  patterns, requester i at [i*LED_W +: LED_W]
//   gnt  one-hot grant (registered)
//   leds driven LED pattern (registered)
// master = requester side, slave = arbiter side.
interface led_rr_arbiter_if
  import led_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LED_W = led_pkg::LED_W
);

  logic [NREQ-1:0]       req;
  logic [NREQ*LED_W-1:0] pat;
  logic [NREQ-1:0]       gnt;
  logic [LED_W-1:0]      leds;

  modport master (output req, output pat, input gnt, input leds);
  modport slave  (input req, input pat, output gnt, output leds);

endinterface

// File: rtl/led_rr_arbiter_tick_gen.sv
// Free-running prescaler: pulses tick for one cycle every PRESC clocks.
//   clk   system clock
//   rstn  synchronous active-low reset
//   tick  registered pulse, high while the count sits at PRESC-1
module tick_gen
  import led_pkg::*;
#(
  parameter int unsigned PRESC = 3000000
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int unsigned CW = (PRESC < 2) ? 1 : $clog2(PRESC);

  logic [CW-1:0] cnt;

  // tick is registered, so it is raised one count early to line up with PRESC-1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CW'(PRESC - 1)) ? '0 : cnt + CW'(1);
      tick <= (cnt == CW'(PRESC - 2));
    end
  end

endmodule

// File: rtl/led_rr_arbiter.sv
// Round-robin owner of the LED bank.
//   clk   system clock
//   rstn  synchronous active-low reset
//   bus   slave side of led_rr_arbiter_if (req/pat in, gnt/leds out)
//   tick  dwell-tick pulse, exported for observability
// A grant lasts DWELL ticks or until the holder drops req; release and
// re-arbitration happen in the same cycle, so there is no idle bubble.
module led_rr_arbiter
  import led_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LED_W = led_pkg::LED_W,
  parameter int unsigned PRESC = 3000000,
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              rstn,
  led_rr_arbiter_if.slave   bus,
  output logic              tick
);

  localparam int unsigned DW = $clog2(DWELL + 1);

  state_e               st_q, st_n;
  logic [NREQ-1:0]      gnt_q, gnt_n;
  logic [LED_W-1:0]     leds_q, leds_n;
  logic [2:0]           gidx_q, gidx_n;
  logic [2:0]           last_q, last_n;
  logic [DW-1:0]        dwell_q, dwell_n;
  logic [MAX_REQ-1:0]   req_ext;
  rr_pick_t             pick;
  logic                 arb;

  tick_gen #(.PRESC(PRESC)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  function automatic logic [LED_W-1:0] pat_of(input logic [NREQ*LED_W-1:0] p,
                                               input logic [2:0]            idx);
    logic [LED_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (idx == 3'(i)) r = p[i*LED_W +: LED_W];
    return r;
  endfunction

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = bus.req;
  end

  always_comb begin
    st_n    = st_q;
    gnt_n   = gnt_q;
    leds_n  = leds_q;
    gidx_n  = gidx_q;
    last_n  = last_q;
    dwell_n = dwell_q;
    arb     = 1'b0;
    pick    = next_index(req_ext, last_q, NREQ);

    unique case (st_q)
      ST_IDLE: begin
        gnt_n  = '0;
        leds_n = '0;
        arb    = |bus.req;
      end
      ST_HOLD: begin
        leds_n = pat_of(bus.pat, gidx_q);
        if (tick) dwell_n = dwell_q - DW'(1);
        // Drop and expiry in the same cycle collapse into one release.
        arb = !req_ext[gidx_q] || (tick && dwell_q == DW'(1));
      end
      default: ;
    endcase

    if (arb) begin
      if (pick.found) begin
        st_n    = ST_HOLD;
        gidx_n  = pick.idx;
        last_n  = pick.idx;
        gnt_n   = NREQ'(1) << pick.idx;
        leds_n  = pat_of(bus.pat, pick.idx);
        dwell_n = DW'(DWELL);
      end else begin
        st_n    = ST_IDLE;
        gnt_n   = '0;
        leds_n  = '0;
        dwell_n = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q    <= ST_IDLE;
      gnt_q   <= '0;
      leds_q  <= '0;
      gidx_q  <= '0;
      last_q  <= 3'(NREQ - 1);
      dwell_q <= '0;
    end else begin
      st_q    <= st_n;
      gnt_q   <= gnt_n;
      leds_q  <= leds_n;
      gidx_q  <= gidx_n;
      last_q  <= last_n;
      dwell_q <= dwell_n;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.leds = leds_q;

endmodule
